// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM state enum, round constants, block type and
// the GF(2^8) arithmetic behind the S-box used by sub_bytes and aes_key_step.
package aes_pkg;

  typedef logic [127:0] aes_block_t;

  localparam int unsigned NUM_ROUNDS_AES128 = 10;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} aes_state_t;

  // Indexed directly by the 4-bit round counter; only entries 1..10 are used.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = gf_xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (square-and-multiply over 0b11111110),
  // followed by the AES affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int unsigned i = 0; i < 8; i++) begin
      inv = gf_mul(inv, inv);
      if (i != 7) inv = gf_mul(inv, x);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_datapath.sv
// Combinational AES round stages. Byte i of a block sits at [127-8i -: 8];
// the state matrix is column-major, so byte 4c+r is row r, column c.
module sub_bytes
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  output logic [127:0] state_out
);
  // Byte-wise S-box substitution.
  always_comb begin
    state_out = '0;
    for (int unsigned i = 0; i < 16; i++)
      state_out[127-8*i -: 8] = sbox(state_in[127-8*i -: 8]);
  end
endmodule

module shift_rows (
  input  logic [127:0] state_in,
  output logic [127:0] state_out
);
  // Row r rotates left by r columns.
  always_comb begin
    state_out = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        state_out[127-8*(4*c+r) -: 8] = state_in[127-8*(4*((c+r)%4)+r) -: 8];
  end
endmodule

module mix_columns
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  output logic [127:0] state_out
);
  logic [7:0] a0, a1, a2, a3;
  // Multiply each column by the fixed {02,03,01,01} circulant matrix.
  always_comb begin
    state_out = '0;
    a0 = '0; a1 = '0; a2 = '0; a3 = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = state_in[127-32*c -: 8];
      a1 = state_in[119-32*c -: 8];
      a2 = state_in[111-32*c -: 8];
      a3 = state_in[103-32*c -: 8];
      state_out[127-32*c -: 8] = gf_xtime(a0) ^ gf_xtime(a1) ^ a1 ^ a2 ^ a3;
      state_out[119-32*c -: 8] = a0 ^ gf_xtime(a1) ^ gf_xtime(a2) ^ a2 ^ a3;
      state_out[111-32*c -: 8] = a0 ^ a1 ^ gf_xtime(a2) ^ gf_xtime(a3) ^ a3;
      state_out[103-32*c -: 8] = gf_xtime(a0) ^ a0 ^ a1 ^ a2 ^ gf_xtime(a3);
    end
  end
endmodule

module add_roundkey (
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  output logic [127:0] state_out
);
  assign state_out = state_in ^ round_key;
endmodule

// File: rtl/aes_key_step.sv
// One step of the AES-128 key schedule: derives round key n from round key n-1.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] prev_key,
  input  logic [7:0]   rcon,
  output logic [127:0] next_key
);
  logic [31:0] w0, w1, w2, w3, temp;

  // RotWord, SubWord and rcon on the last word, then chain through the words.
  always_comb begin
    w0   = prev_key[127:96];
    w1   = prev_key[95:64];
    w2   = prev_key[63:32];
    w3   = prev_key[31:0];
    temp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
           ^ {rcon, 24'h000000};
    next_key[127:96] = w0 ^ temp;
    next_key[95:64]  = w1 ^ w0 ^ temp;
    next_key[63:32]  = w2 ^ w1 ^ w0 ^ temp;
    next_key[31:0]   = w3 ^ w2 ^ w1 ^ w0 ^ temp;
  end
endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer: one round per cycle, key expanded on
// the fly, valid/ready on both sides, one block in flight.
// Optional macro AES_CTRL_PERF_EN adds perf_blocks / perf_stall counters.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 10,
  parameter int unsigned STATE_W    = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_plaintext,
  input  logic [STATE_W-1:0] in_key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_ciphertext,
  output logic               busy
`ifdef AES_CTRL_PERF_EN
  ,
  output logic [31:0]        perf_blocks,
  output logic [31:0]        perf_stall
`endif
);

  if (NUM_ROUNDS != NUM_ROUNDS_AES128) begin : g_bad_rounds
    $error("aes_round_ctrl supports only NUM_ROUNDS = 10");
  end
  if (STATE_W != 128) begin : g_bad_width
    $error("aes_round_ctrl requires STATE_W = 128");
  end

  localparam logic [3:0] LAST_FULL_ROUND = 4'(NUM_ROUNDS - 1);

  aes_state_t fsm_q, fsm_d;
  aes_block_t state_reg, state_d, key_reg, key_d;
  aes_block_t sb, sr, mc, next_key, ark_state, ark_key, ark_out;
  logic [3:0] round_cnt, cnt_d;

  sub_bytes    u_sub_bytes   (.state_in(state_reg), .state_out(sb));
  shift_rows   u_shift_rows  (.state_in(sb), .state_out(sr));
  mix_columns  u_mix_columns (.state_in(sr), .state_out(mc));
  add_roundkey u_add_roundkey(.state_in(ark_state), .round_key(ark_key), .state_out(ark_out));
  aes_key_step u_key_step    (.prev_key(key_reg), .rcon(RCON[round_cnt]), .next_key(next_key));

  // A single add_roundkey serves both the initial whitening and every round.
  always_comb begin
    ark_state = mc;
    ark_key   = next_key;
    case (fsm_q)
      IDLE: begin
        ark_state = in_plaintext;
        ark_key   = in_key;
      end
      FINAL:   ark_state = sr;
      default: ;
    endcase
  end

  // Next-state, datapath load and handshake outputs.
  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_reg;
    key_d     = key_reg;
    cnt_d     = round_cnt;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = ark_out;
          key_d   = in_key;
          cnt_d   = 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        state_d = ark_out;
        key_d   = next_key;
        cnt_d   = round_cnt + 4'd1;
        if (round_cnt == LAST_FULL_ROUND) fsm_d = FINAL;
      end
      FINAL: begin
        state_d = ark_out;
        key_d   = next_key;
        fsm_d   = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          fsm_d = IDLE;
          cnt_d = '0;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // State, key and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= IDLE;
      state_reg <= '0;
      key_reg   <= '0;
      round_cnt <= '0;
    end else begin
      fsm_q     <= fsm_d;
      state_reg <= state_d;
      key_reg   <= key_d;
      round_cnt <= cnt_d;
    end
  end

  assign out_ciphertext = state_reg;
  assign busy           = (fsm_q != IDLE);

`ifdef AES_CTRL_PERF_EN
  // Saturating counters of completed handshakes and output stall cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_blocks <= '0;
      perf_stall  <= '0;
    end else begin
      if (out_valid && out_ready && (perf_blocks != '1)) perf_blocks <= perf_blocks + 32'd1;
      if (out_valid && !out_ready && (perf_stall != '1)) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
